// File: rtl/lstm_fx_pkg.sv
// Fixed-point format shared by the LSTM activation and gradient units.
// Q3.6 operands, with stage bundles for the tanh gradient pipe.
package lstm_fx_pkg;

  localparam int BIT_SIZE  = 10;
  localparam int FRAC_BITS = 6;
  localparam int ONE       = 1 << FRAC_BITS;
  localparam int HALF_LSB  = 1 << (FRAC_BITS - 1);
  localparam int SAT_MAX   = (1 << (BIT_SIZE - 1)) - 1;
  localparam int SAT_MIN   = -(1 << (BIT_SIZE - 1));

  typedef logic signed [BIT_SIZE-1:0]   fx_t;
  typedef logic signed [2*BIT_SIZE-1:0] fx2_t;

  typedef struct packed {
    fx2_t sq;
    fx_t  dy;
  } s1_t;

  typedef struct packed {
    fx_t d;
    fx_t dy;
  } s2_t;

endpackage

// File: rtl/tanh_grad_if.sv
// Operand/result stream bundle for the tanh gradient unit.
// Master is the gradient source and result sink; slave is the unit.
interface tanh_grad_if;
  import lstm_fx_pkg::*;

  logic in_valid;
  logic in_ready;
  fx_t  y_in;
  fx_t  dy_in;
  logic out_valid;
  logic out_ready;
  fx_t  dx_out;

  modport master (
    output in_valid, y_in, dy_in, out_ready,
    input  in_ready, out_valid, dx_out
  );

  modport slave (
    input  in_valid, y_in, dy_in, out_ready,
    output in_ready, out_valid, dx_out
  );

endinterface

// File: rtl/fx_mul_rnd.sv
// Signed fixed-point multiply with round-half-up and saturation.
// Shared by the gradient units of the LSTM datapath.
module fx_mul_rnd
  import lstm_fx_pkg::*;
(
  input  fx_t a,
  input  fx_t b,
  output fx_t r
);

  localparam int PW = 2 * BIT_SIZE + 1;

  logic signed [PW-1:0] p;
  logic signed [PW-1:0] pr;
  logic signed [PW-1:0] sh;

  assign p  = PW'(a) * PW'(b);
  assign pr = p + PW'(HALF_LSB);
  assign sh = pr >>> FRAC_BITS;

  always_comb begin
    r = sh[BIT_SIZE-1:0];
    if (sh > PW'(SAT_MAX)) begin
      r = fx_t'(SAT_MAX);
    end else if (sh < PW'(SAT_MIN)) begin
      r = fx_t'(SAT_MIN);
    end
  end

endmodule

// File: rtl/tanh_grad.sv
// Backward tanh: dx = dy * (1 - y^2), three-stage pipe.
// A single enable stalls every stage together when the output is blocked.
module tanh_grad
  import lstm_fx_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  tanh_grad_if.slave bus
);

  logic en;
  logic v1, v2, v3;
  s1_t  s1_q;
  s2_t  s2_q;
  fx_t  dx_q;
  fx2_t sqs;
  fx2_t diff;
  fx_t  d_c;
  fx_t  r_c;

  assign en           = !v3 || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid = v3;
  assign bus.dx_out   = dx_q;

  // |y| >= 1.0 drives 1 - y^2 negative; the slope is zero there
  always_comb begin
    sqs  = s1_q.sq >>> FRAC_BITS;
    diff = fx2_t'(ONE) - sqs;
    d_c  = diff[BIT_SIZE-1:0];
    if (diff[2*BIT_SIZE-1]) begin
      d_c = '0;
    end
  end

  fx_mul_rnd u_mul (
    .a (s2_q.dy),
    .b (s2_q.d),
    .r (r_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      dx_q <= '0;
    end else if (en) begin
      v1 <= bus.in_valid;
      v2 <= v1;
      v3 <= v2;
      if (bus.in_valid) begin
        s1_q.sq <= fx2_t'(bus.y_in) * fx2_t'(bus.y_in);
        s1_q.dy <= bus.dy_in;
      end
      if (v1) begin
        s2_q.d  <= d_c;
        s2_q.dy <= s1_q.dy;
      end
      if (v2) begin
        dx_q <= r_c;
      end
    end
  end

endmodule

// File: tb/tb_tanh_grad.sv
// Self-checking bench for tanh_grad: directed table, backpressure,
// reset mid-stream and a randomized run against an arithmetic model.
module tb_tanh_grad;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  tanh_grad_if bus();

  tanh_grad dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y;
    int dy;
    int ex;
  } vec_t;

  vec_t tbl[10];
  int   checks = 0;
  int   errors = 0;
  int   npop = 0;
  bit   mon_en = 1'b0;
  int   expq[$];

  function automatic int model(int y, int dy);
    int sq;
    int d;
    int p;
    int r;
    sq = y * y;
    d = 64 - (sq >>> 6);
    if (d < 0) d = 0;
    p = dy * d;
    r = (p + 32) >>> 6;
    if (r > 511) r = 511;
    if (r < -512) r = -512;
    return r;
  endfunction

  task automatic chk(string nm, int act, int ex);
    checks++;
    if (act != ex) begin
      errors++;
      $display("FAIL %s got=%0d need=%0d", nm, act, ex);
    end
  endtask

  // one clock: observe handshakes mid-cycle, then step past the edge
  task automatic tick(output bit acc);
    int e;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    if (mon_en) begin
      if (acc) expq.push_back(model(int'(bus.y_in), int'(bus.dy_in)));
      if (bus.out_valid && bus.out_ready) begin
        npop++;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra got=%0d need=none", bus.dx_out);
        end else begin
          e = expq.pop_front();
          chk("sb_dx", int'(bus.dx_out), e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(string nm, int y, int dy, int ex);
    bit acc;
    int n;
    bus.in_valid  = 1'b1;
    bus.y_in      = 10'(y);
    bus.dy_in     = 10'(dy);
    bus.out_ready = 1'b1;
    tick(acc);
    chk({nm, "_acc"}, int'(acc), 1);
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 10) begin
      tick(acc);
      n++;
    end
    chk({nm, "_lat"}, n, 3);
    chk({nm, "_dx"}, int'(bus.dx_out), ex);
    tick(acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout need=finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    int k;
    int held;

    tbl[0] = '{0, 64, 64};
    tbl[1] = '{32, 64, 48};
    tbl[2] = '{-32, 64, 48};
    tbl[3] = '{64, 100, 0};
    tbl[4] = '{80, 100, 0};
    tbl[5] = '{32, 3, 2};
    tbl[6] = '{32, -3, -2};
    tbl[7] = '{8, -64, -63};
    tbl[8] = '{-64, 50, 0};
    tbl[9] = '{-512, -512, 0};

    bus.in_valid  = 1'b0;
    bus.y_in      = '0;
    bus.dy_in     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov", int'(bus.out_valid), 0);
    chk("rst_dx", int'(bus.dx_out), 0);
    chk("rst_ir", int'(bus.in_ready), 1);
    rst_n = 1'b1;
    tick(acc);

    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i].y, tbl[i].dy, tbl[i].ex);
    end

    // backpressure: 5 pairs, sink stalls from cycle 4 to 9
    mon_en = 1'b1;
    npop = 0;
    k = 0;
    held = 0;
    for (int c = 0; c < 20; c++) begin
      bus.out_ready = !(c >= 4 && c < 10);
      bus.in_valid  = (k < 5);
      bus.y_in      = 10'(k * 16 - 40);
      bus.dy_in     = 10'(64 - k * 30);
      if (c == 5) held = int'(bus.dx_out);
      if (c == 8) begin
        chk("bp_ir", int'(bus.in_ready), 0);
        chk("bp_ov", int'(bus.out_valid), 1);
        chk("bp_hold", int'(bus.dx_out), held);
      end
      tick(acc);
      if (acc) k++;
    end
    bus.in_valid = 1'b0;
    chk("bp_count", npop, 5);
    chk("bp_left", expq.size(), 0);

    // reset with two items in flight
    mon_en = 1'b0;
    expq.delete();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.y_in      = 10'(16);
    bus.dy_in     = 10'(64);
    tick(acc);
    bus.y_in = 10'(-16);
    tick(acc);
    bus.in_valid = 1'b0;
    tick(acc);
    chk("mid_ov", int'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_ov", int'(bus.out_valid), 0);
    chk("mrst_dx", int'(bus.dx_out), 0);
    chk("mrst_ir", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_vec("post_rst", 0, -64, -64);

    // randomized stream, source holds a pair until it is taken
    mon_en = 1'b1;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick(acc);
      if (!bus.in_valid || acc) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.y_in     = 10'($urandom);
        bus.dy_in    = 10'($urandom);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) tick(acc);
    chk("rnd_left", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
